// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares one DDR3 burst interface between the loader (port 0) and
// the video path (port 1). A grant is held for one complete read or write burst.
// Optional feature macro DDR_ARBITER_RR_EN: round-robin tie-break using a `last`
// register. Without it, port 1 has fixed priority on ties.
module ddr_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BURST_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    in0_rd,
    input  logic                    in0_wr,
    input  logic [ADDR_WIDTH-1:0]   in0_addr,
    input  logic [BURST_WIDTH-1:0]  in0_burst_length,
    input  logic [DATA_WIDTH-1:0]   in0_din,
    input  logic [DATA_WIDTH/8-1:0] in0_mask,
    output logic                    in0_wait_req,
    output logic                    in0_valid,
    output logic [DATA_WIDTH-1:0]   in0_dout,

    input  logic                    in1_rd,
    input  logic                    in1_wr,
    input  logic [ADDR_WIDTH-1:0]   in1_addr,
    input  logic [BURST_WIDTH-1:0]  in1_burst_length,
    input  logic [DATA_WIDTH-1:0]   in1_din,
    input  logic [DATA_WIDTH/8-1:0] in1_mask,
    output logic                    in1_wait_req,
    output logic                    in1_valid,
    output logic [DATA_WIDTH-1:0]   in1_dout,

    output logic                    ddr_rd,
    output logic                    ddr_wr,
    output logic [ADDR_WIDTH-1:0]   ddr_addr,
    output logic [BURST_WIDTH-1:0]  ddr_burst_length,
    output logic [DATA_WIDTH-1:0]   ddr_din,
    output logic [DATA_WIDTH/8-1:0] ddr_mask,
    input  logic                    ddr_wait_req,
    input  logic                    ddr_valid,
    input  logic [DATA_WIDTH-1:0]   ddr_dout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_CMD  = 2'd1,
        READ_DATA = 2'd2,
        WRITE     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic [BURST_WIDTH-1:0] count_q, count_d;
    logic [BURST_WIDTH-1:0] len_q, len_d;
    logic [BURST_WIDTH-1:0] len_last;

    logic                   req0, req1;
    logic                   win;
    logic                   win_rd;
    logic [BURST_WIDTH-1:0] win_len;
    logic                   sel_rd, sel_wr;
    logic                   gnt_wait, gnt_valid;
    logic                   is_last_beat;

    assign req0 = in0_rd | in0_wr;
    assign req1 = in1_rd | in1_wr;

`ifdef DDR_ARBITER_RR_EN
    logic last_q, last_d;

    // Round-robin: on a tie the port that was not served last wins
    assign win = (req0 & req1) ? ~last_q : req1;
`else
    // Fixed priority: video (port 1) wins ties
    assign win = req1;
`endif

    assign win_rd  = win ? in1_rd : in0_rd;
    assign win_len = win ? in1_burst_length : in0_burst_length;

    // Granted-port command/data mux toward the DDR interface
    assign sel_rd           = grant_q ? in1_rd : in0_rd;
    assign sel_wr           = grant_q ? in1_wr : in0_wr;
    assign ddr_addr         = grant_q ? in1_addr : in0_addr;
    assign ddr_burst_length = grant_q ? in1_burst_length : in0_burst_length;
    assign ddr_din          = grant_q ? in1_din : in0_din;
    assign ddr_mask         = grant_q ? in1_mask : in0_mask;
    assign ddr_rd           = (state_q == READ_CMD) & sel_rd;
    assign ddr_wr           = (state_q == WRITE) & sel_wr;

    // Read data goes to both ports; only the granted one sees valid
    assign in0_dout = ddr_dout;
    assign in1_dout = ddr_dout;

    assign len_last     = len_q - BURST_WIDTH'(1);
    assign is_last_beat = (count_q == len_last);

    // Stall/valid steering: only the granted port in a command phase sees DDR backpressure
    always_comb begin
        gnt_wait  = 1'b1;
        gnt_valid = 1'b0;
        if ((state_q == READ_CMD) || (state_q == WRITE)) begin
            gnt_wait = ddr_wait_req;
        end
        if (state_q == READ_DATA) begin
            gnt_valid = ddr_valid;
        end
        in0_wait_req = grant_q ? 1'b1 : gnt_wait;
        in1_wait_req = grant_q ? gnt_wait : 1'b1;
        in0_valid    = grant_q ? 1'b0 : gnt_valid;
        in1_valid    = grant_q ? gnt_valid : 1'b0;
    end

    // Next-state: arbitrate in IDLE, then track beats until the burst completes
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        count_d = count_q;
        len_d   = len_q;
`ifdef DDR_ARBITER_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    grant_d = win;
                    len_d   = (win_len == '0) ? BURST_WIDTH'(1) : win_len;
                    count_d = '0;
                    state_d = win_rd ? READ_CMD : WRITE;
`ifdef DDR_ARBITER_RR_EN
                    last_d  = win;
`endif
                end
            end
            READ_CMD: begin
                if (ddr_rd & ~ddr_wait_req) begin
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                if (ddr_valid) begin
                    count_d = count_q + BURST_WIDTH'(1);
                    if (is_last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (ddr_wr & ~ddr_wait_req) begin
                    count_d = count_q + BURST_WIDTH'(1);
                    if (is_last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst bookkeeping registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            count_q <= '0;
            len_q   <= BURST_WIDTH'(1);
`ifdef DDR_ARBITER_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            count_q <= count_d;
            len_q   <= len_d;
`ifdef DDR_ARBITER_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: requester and DDR-side behaviour models,
// a transaction-level expectation of service order and data, randomized traffic.
module tb_ddr_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 8;
    localparam int unsigned MW = DW / 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in0_rd, in0_wr, in1_rd, in1_wr;
    logic [AW-1:0] in0_addr, in1_addr;
    logic [BW-1:0] in0_burst_length, in1_burst_length;
    logic [DW-1:0] in0_din, in1_din;
    logic [MW-1:0] in0_mask, in1_mask;
    logic          in0_wait_req, in1_wait_req, in0_valid, in1_valid;
    logic [DW-1:0] in0_dout, in1_dout;
    logic          ddr_rd, ddr_wr;
    logic [AW-1:0] ddr_addr;
    logic [BW-1:0] ddr_burst_length;
    logic [DW-1:0] ddr_din;
    logic [MW-1:0] ddr_mask;
    logic          ddr_wait_req, ddr_valid;
    logic [DW-1:0] ddr_dout;

    ddr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .clock(clock), .reset(reset),
        .in0_rd(in0_rd), .in0_wr(in0_wr), .in0_addr(in0_addr),
        .in0_burst_length(in0_burst_length), .in0_din(in0_din), .in0_mask(in0_mask),
        .in0_wait_req(in0_wait_req), .in0_valid(in0_valid), .in0_dout(in0_dout),
        .in1_rd(in1_rd), .in1_wr(in1_wr), .in1_addr(in1_addr),
        .in1_burst_length(in1_burst_length), .in1_din(in1_din), .in1_mask(in1_mask),
        .in1_wait_req(in1_wait_req), .in1_valid(in1_valid), .in1_dout(in1_dout),
        .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
        .ddr_burst_length(ddr_burst_length), .ddr_din(ddr_din), .ddr_mask(ddr_mask),
        .ddr_wait_req(ddr_wait_req), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } ev_t;

    int tests = 0;
    int fails = 0;

    // Request descriptors per port
    logic          r_rd   [2];
    logic          r_both [2];
    logic [AW-1:0] r_addr [2];
    logic [BW-1:0] r_len  [2];
    logic [DW-1:0] wd [2][256];
    logic [MW-1:0] wm [2][256];
    logic          model_last;

    // Expected and observed transaction logs
    ev_t           exp_ev[$], got_ev[$];
    int            got_cyc[$];
    logic [DW-1:0] exp_rx0[$], exp_rx1[$], got_rx0[$], got_rx1[$];
    logic [DW-1:0] pend[$];

    int  viol, ev_bad, rx_bad, wr_cycles, addr_bad;
    bit  timed_out;
    ev_t first_got_ev, first_exp_ev;
    logic [DW-1:0] first_got_rx, first_exp_rx;

    function automatic int eff_len(input logic [BW-1:0] l);
        return (l == '0) ? 1 : int'(l);
    endfunction

    function automatic ev_t mk_ev(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] l,
                                  input logic [DW-1:0] d, input logic [MW-1:0] m);
        ev_t e;
        e.wr = wr; e.addr = a; e.len = l; e.data = d; e.mask = m;
        return e;
    endfunction

    task automatic drive_idle();
        in0_rd = 0; in0_wr = 0; in0_addr = '0; in0_burst_length = '0; in0_din = '0; in0_mask = '0;
        in1_rd = 0; in1_wr = 0; in1_addr = '0; in1_burst_length = '0; in1_din = '0; in1_mask = '0;
        ddr_wait_req = 0; ddr_valid = 0; ddr_dout = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        @(negedge clock); reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        model_last = 1'b0;
    endtask

    task automatic set_req(input int p, input logic rd, input logic both,
                           input logic [AW-1:0] a, input logic [BW-1:0] l);
        r_rd[p] = rd; r_both[p] = both; r_addr[p] = a; r_len[p] = l;
        for (int k = 0; k < 256; k++) begin
            wd[p][k] = {$urandom, $urandom};
            wm[p][k] = MW'($urandom);
        end
    endtask

    // Reference: one served burst is one read command plus its beats, or N write beats
    task automatic model_serve(input int p);
        int n;
        n = eff_len(r_len[p]);
        if (r_rd[p]) begin
            exp_ev.push_back(mk_ev(1'b0, r_addr[p], r_len[p], '0, '0));
            for (int k = 0; k < n; k++) begin
                if (p == 0) exp_rx0.push_back({r_addr[p], 32'(k)});
                else        exp_rx1.push_back({r_addr[p], 32'(k)});
            end
        end else begin
            for (int k = 0; k < n; k++)
                exp_ev.push_back(mk_ev(1'b1, r_addr[p], r_len[p], wd[p][k], wm[p][k]));
        end
        model_last = (p != 0);
    endtask

    // Reference service order for requests raised in the same cycle
    task automatic model_plan(input bit a0, input bit a1);
        int w;
        exp_ev.delete(); exp_rx0.delete(); exp_rx1.delete();
        if (a0 && a1) begin
`ifdef DDR_ARBITER_RR_EN
            w = model_last ? 0 : 1;
`else
            w = 1;
`endif
            model_serve(w);
            model_serve(1 - w);
        end else if (a0) begin
            model_serve(0);
        end else if (a1) begin
            model_serve(1);
        end
    endtask

    // Cycle-stepped requesters plus DDR responder; records what the DDR side saw
    task automatic run_bursts(input bit a0, input bit a1, input int wait_pct, input int gap_pct,
                              input int extra, input int stall_from, input int stall_n);
        bit act [2]; bit cmdp [2]; int wb [2]; int rb [2];
        bit drv_rd [2]; bit drv_wr [2]; logic [DW-1:0] drv_din [2]; logic [MW-1:0] drv_mask [2];
        bit wq, vl, in_wr_burst, have_first;
        logic [DW-1:0] dq; logic [AW-1:0] hold_addr; logic [BW-1:0] hold_len;
        int tail;
        act[0] = a0; act[1] = a1;
        cmdp[0] = a0 && r_rd[0]; cmdp[1] = a1 && r_rd[1];
        wb[0] = 0; wb[1] = 0; rb[0] = 0; rb[1] = 0;
        got_ev.delete(); got_cyc.delete(); got_rx0.delete(); got_rx1.delete(); pend.delete();
        viol = 0; timed_out = 1; wr_cycles = 0; addr_bad = 0; tail = 0;
        in_wr_burst = 0; hold_addr = '0; hold_len = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            for (int p = 0; p < 2; p++) begin
                drv_rd[p]   = act[p] && r_rd[p] && cmdp[p];
                drv_wr[p]   = act[p] && (r_rd[p] ? (r_both[p] && cmdp[p]) : (wb[p] < eff_len(r_len[p])));
                drv_din[p]  = wd[p][8'(wb[p])];
                drv_mask[p] = wm[p][8'(wb[p])];
            end
            in0_rd = drv_rd[0]; in0_wr = drv_wr[0]; in0_addr = r_addr[0];
            in0_burst_length = r_len[0]; in0_din = drv_din[0]; in0_mask = drv_mask[0];
            in1_rd = drv_rd[1]; in1_wr = drv_wr[1]; in1_addr = r_addr[1];
            in1_burst_length = r_len[1]; in1_din = drv_din[1]; in1_mask = drv_mask[1];
            if (c >= stall_from && c < stall_from + stall_n) ddr_wait_req = 1;
            else ddr_wait_req = ($urandom_range(0, 99) < wait_pct);
            if (pend.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                ddr_valid = 1; ddr_dout = pend[0];
            end else begin
                ddr_valid = 0; ddr_dout = {$urandom, $urandom};
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                wq = (p == 0) ? in0_wait_req : in1_wait_req;
                vl = (p == 0) ? in0_valid : in1_valid;
                dq = (p == 0) ? in0_dout : in1_dout;
                if (!wq) begin
                    if (!act[p] || (r_rd[p] && !cmdp[p])) viol++;
                    else if (r_rd[p]) cmdp[p] = 0;
                    else begin
                        wb[p]++;
                        if (wb[p] == eff_len(r_len[p])) act[p] = 0;
                    end
                end
                if (vl) begin
                    if (p == 0) got_rx0.push_back(dq); else got_rx1.push_back(dq);
                    if (act[p] && r_rd[p] && !cmdp[p]) begin
                        rb[p]++;
                        if (rb[p] == eff_len(r_len[p])) act[p] = 0;
                    end else viol++;
                end
            end
            if (ddr_rd && ddr_wr) viol++;
            if (ddr_wr) begin
                wr_cycles++;
                if (!in_wr_burst) begin
                    hold_addr = ddr_addr; hold_len = ddr_burst_length;
                end else if (ddr_addr !== hold_addr || ddr_burst_length !== hold_len) addr_bad++;
            end
            in_wr_burst = ddr_wr;
            if (ddr_rd && !ddr_wait_req) begin
                got_ev.push_back(mk_ev(1'b0, ddr_addr, ddr_burst_length, '0, '0));
                got_cyc.push_back(c);
                for (int k = 0; k < eff_len(ddr_burst_length) + extra; k++)
                    pend.push_back({ddr_addr, 32'(k)});
            end
            if (ddr_wr && !ddr_wait_req) begin
                got_ev.push_back(mk_ev(1'b1, ddr_addr, ddr_burst_length, ddr_din, ddr_mask));
                got_cyc.push_back(c);
            end
            if (ddr_valid) void'(pend.pop_front());
            if (!act[0] && !act[1] && pend.size() == 0) tail++; else tail = 0;
            if (tail == 3) begin
                timed_out = 0;
                break;
            end
        end
        drive_idle();
        // Summarise log differences for the calling test
        ev_bad = (got_ev.size() != exp_ev.size()) ? 1 : 0;
        have_first = 0; first_got_ev = '0; first_exp_ev = '0;
        for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
            if (got_ev[i] !== exp_ev[i]) begin
                ev_bad++;
                if (!have_first) begin
                    first_got_ev = got_ev[i]; first_exp_ev = exp_ev[i]; have_first = 1;
                end
            end
        end
        rx_bad = (got_rx0.size() != exp_rx0.size() || got_rx1.size() != exp_rx1.size()) ? 1 : 0;
        have_first = 0; first_got_rx = '0; first_exp_rx = '0;
        for (int i = 0; i < got_rx0.size() && i < exp_rx0.size(); i++)
            if (got_rx0[i] !== exp_rx0[i]) begin
                rx_bad++;
                if (!have_first) begin first_got_rx = got_rx0[i]; first_exp_rx = exp_rx0[i]; have_first = 1; end
            end
        for (int i = 0; i < got_rx1.size() && i < exp_rx1.size(); i++)
            if (got_rx1[i] !== exp_rx1[i]) begin
                rx_bad++;
                if (!have_first) begin first_got_rx = got_rx1[i]; first_exp_rx = exp_rx1[i]; have_first = 1; end
            end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        in0_rd = 1; in1_wr = 1; ddr_valid = 1; ddr_wait_req = 0;
        repeat (2) @(negedge clock);
        #1;
        tests++;
        if ({ddr_rd, ddr_wr} !== 2'b00) begin
            fails++; $display("FAIL reset_ddr_cmd: got rd/wr=%b want 00", {ddr_rd, ddr_wr});
        end
        tests++;
        if ({in0_wait_req, in1_wait_req} !== 2'b11) begin
            fails++; $display("FAIL reset_wait_req: got %b want 11", {in0_wait_req, in1_wait_req});
        end
        tests++;
        if ({in0_valid, in1_valid} !== 2'b00) begin
            fails++; $display("FAIL reset_valid: got %b want 00", {in0_valid, in1_valid});
        end
        drive_idle();
        @(negedge clock); reset = 0;
        model_last = 1'b0;
    endtask

    task automatic test_single_read();
        set_req(0, 1'b1, 1'b0, 32'h100, 8'd4);
        set_req(1, 1'b0, 1'b0, 32'h0, 8'd1);
        model_plan(1, 0);
        run_bursts(1, 0, 0, 30, 0, -1, 0);
        tests++;
        if (timed_out !== 1'b0) begin fails++; $display("FAIL read0_timeout: got %0d want 0", timed_out); end
        tests++;
        if (viol !== 0) begin fails++; $display("FAIL read0_protocol: got %0d violations want 0", viol); end
        tests++;
        if (ev_bad !== 0) begin
            fails++; $display("FAIL read0_ddr_cmd: got %h want %h (%0d bad)", first_got_ev, first_exp_ev, ev_bad);
        end
        tests++;
        if (got_rx0.size() !== 4 || rx_bad !== 0) begin
            fails++; $display("FAIL read0_beats: got %0d beats (first bad %h) want 4 beats (%h)",
                              got_rx0.size(), first_got_rx, first_exp_rx);
        end
        tests++;
        if (got_cyc.size() < 1 || got_cyc[0] !== 1) begin
            fails++; $display("FAIL read0_latency: got cycle %0d want 1", (got_cyc.size() > 0) ? got_cyc[0] : -1);
        end
    endtask

    task automatic test_write_stall();
        set_req(0, 1'b0, 1'b0, 32'h0, 8'd1);
        set_req(1, 1'b0, 1'b0, 32'h0004_2A08, 8'd2);
        model_plan(0, 1);
        run_bursts(0, 1, 0, 0, 0, 2, 3);
        tests++;
        if (timed_out !== 1'b0 || viol !== 0) begin
            fails++; $display("FAIL write1_protocol: got timeout=%0d viol=%0d want 0/0", timed_out, viol);
        end
        tests++;
        if (ev_bad !== 0) begin
            fails++; $display("FAIL write1_beats: got %h want %h (%0d bad)", first_got_ev, first_exp_ev, ev_bad);
        end
        tests++;
        if (addr_bad !== 0 || wr_cycles !== 5) begin
            fails++; $display("FAIL write1_hold: got addr_changes=%0d wr_cycles=%0d want 0/5", addr_bad, wr_cycles);
        end
        tests++;
        if (got_cyc.size() !== 2 || got_cyc[got_cyc.size() - 1] !== 5) begin
            fails++; $display("FAIL write1_stall_timing: got %0d accepts want 2 with last at cycle 5", got_cyc.size());
        end
    endtask

    task automatic test_tie();
        apply_reset();
        for (int t = 0; t < 2; t++) begin
            set_req(0, 1'b0, 1'b0, 32'h0000_1000, 8'd1);
            set_req(1, 1'b0, 1'b0, 32'h0000_2000, 8'd1);
            model_plan(1, 1);
            run_bursts(1, 1, 0, 0, 0, -1, 0);
            tests++;
            if (timed_out !== 1'b0 || viol !== 0 || ev_bad !== 0) begin
                fails++; $display("FAIL tie%0d_order: got %h want %h (timeout=%0d viol=%0d)",
                                  t, first_got_ev, first_exp_ev, timed_out, viol);
            end
            tests++;
            if (got_ev.size() < 1 || got_ev[0].addr !== 32'h0000_2000) begin
                fails++; $display("FAIL tie%0d_first: got addr %h want 00002000",
                                  t, (got_ev.size() > 0) ? got_ev[0].addr : '0);
            end
            tests++;
            if (got_cyc.size() !== 2 || (got_cyc[1] - got_cyc[0]) !== 2) begin
                fails++; $display("FAIL tie%0d_turnaround: got %0d events want 2 spaced by 2 cycles", t, got_cyc.size());
            end
        end
    endtask

    task automatic test_len_zero();
        set_req(0, 1'b1, 1'b0, 32'h0000_0340, 8'd0);
        set_req(1, 1'b0, 1'b0, 32'h0, 8'd1);
        model_plan(1, 0);
        run_bursts(1, 0, 20, 0, 1, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || viol !== 0 || ev_bad !== 0) begin
            fails++; $display("FAIL len0_cmd: got %h want %h (timeout=%0d viol=%0d)",
                              first_got_ev, first_exp_ev, timed_out, viol);
        end
        tests++;
        if (got_rx0.size() !== 1 || rx_bad !== 0) begin
            fails++; $display("FAIL len0_beats: got %0d valid beats want 1", got_rx0.size());
        end
    endtask

    task automatic test_rd_wr_both();
        set_req(0, 1'b1, 1'b1, 32'h0000_0888, 8'd1);
        set_req(1, 1'b0, 1'b0, 32'h0, 8'd1);
        model_plan(1, 0);
        run_bursts(1, 0, 10, 10, 0, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || viol !== 0 || ev_bad !== 0 || rx_bad !== 0) begin
            fails++; $display("FAIL rdwr_read: got %h want %h (timeout=%0d viol=%0d rx_bad=%0d)",
                              first_got_ev, first_exp_ev, timed_out, viol, rx_bad);
        end
        tests++;
        if (wr_cycles !== 0) begin
            fails++; $display("FAIL rdwr_no_write: got %0d ddr_wr cycles want 0", wr_cycles);
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        drive_idle();
        @(negedge clock);
        in0_rd = 1; in0_addr = 32'h0000_0200; in0_burst_length = 8'd8;
        @(negedge clock); #1;
        tests++;
        if (ddr_rd !== 1'b1 || ddr_addr !== 32'h0000_0200) begin
            fails++; $display("FAIL areset_cmd: got rd=%b addr=%h want 1/00000200", ddr_rd, ddr_addr);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            in0_rd = 0; d = {$urandom, $urandom}; ddr_valid = 1; ddr_dout = d;
            #1;
            tests++;
            if (in0_valid !== 1'b1 || in0_dout !== d) begin
                fails++; $display("FAIL areset_beat%0d: got valid=%b data=%h want 1/%h", b, in0_valid, in0_dout, d);
            end
        end
        #2 reset = 1;
        #1;
        tests++;
        if ({ddr_rd, ddr_wr, in0_wait_req, in1_wait_req, in0_valid, in1_valid} !== 6'b001100) begin
            fails++; $display("FAIL areset_immediate: got rd,wr,wr0,wr1,v0,v1=%b want 001100",
                              {ddr_rd, ddr_wr, in0_wait_req, in1_wait_req, in0_valid, in1_valid});
        end
        @(negedge clock); reset = 0; model_last = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clock);
            ddr_valid = 1; ddr_dout = {$urandom, $urandom};
            #1;
            tests++;
            if ({in0_valid, in1_valid} !== 2'b00) begin
                fails++; $display("FAIL areset_trailing%0d: got valid=%b want 00", b, {in0_valid, in1_valid});
            end
        end
        drive_idle();
        set_req(0, 1'b0, 1'b0, 32'h0, 8'd1);
        set_req(1, 1'b1, 1'b0, 32'h0000_0400, 8'd3);
        model_plan(0, 1);
        run_bursts(0, 1, 20, 20, 0, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || viol !== 0 || ev_bad !== 0 || rx_bad !== 0) begin
            fails++; $display("FAIL areset_recover: got %h want %h (timeout=%0d viol=%0d rx_bad=%0d)",
                              first_got_ev, first_exp_ev, timed_out, viol, rx_bad);
        end
    endtask

    task automatic test_max_burst();
        set_req(0, 1'b0, 1'b0, 32'h0, 8'd1);
        set_req(1, 1'b1, 1'b0, 32'h00FF_0000, 8'd255);
        model_plan(0, 1);
        run_bursts(0, 1, 10, 10, 0, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || viol !== 0 || ev_bad !== 0 || got_rx1.size() !== 255 || rx_bad !== 0) begin
            fails++; $display("FAIL max_burst: got %0d beats (timeout=%0d viol=%0d rx_bad=%0d) want 255",
                              got_rx1.size(), timed_out, viol, rx_bad);
        end
    endtask

    task automatic test_random();
        int sel;
        bit a0, a1;
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(1, 3));
            a0 = sel[0]; a1 = sel[1];
            for (int p = 0; p < 2; p++) begin
                set_req(p, 1'($urandom_range(0, 1)), 1'b0, AW'($urandom) & ~AW'(7),
                        ($urandom_range(0, 4) == 0) ? BW'($urandom_range(0, 40)) : BW'($urandom_range(0, 8)));
            end
            model_plan(a0, a1);
            run_bursts(a0, a1, int'($urandom_range(0, 50)), int'($urandom_range(0, 50)), 0, -1, 0);
            tests++;
            if (timed_out !== 1'b0 || viol !== 0) begin
                fails++; $display("FAIL rand%0d_protocol: got timeout=%0d viol=%0d want 0/0", it, timed_out, viol);
            end
            tests++;
            if (ev_bad !== 0) begin
                fails++; $display("FAIL rand%0d_ddr_log: got %h want %h (%0d bad, %0d vs %0d events)",
                                  it, first_got_ev, first_exp_ev, ev_bad, got_ev.size(), exp_ev.size());
            end
            tests++;
            if (rx_bad !== 0) begin
                fails++; $display("FAIL rand%0d_read_data: got %h want %h (%0d bad)", it, first_got_rx, first_exp_rx, rx_bad);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_last = 1'b0;
        drive_idle();
        test_reset();
        test_single_read();
        test_write_stall();
        test_tie();
        test_len_zero();
        test_rd_wr_both();
        test_async_reset();
        test_max_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
